rx_poll_arbiter: RTL and testbench
==================================

RX_POLL_ARBITER -- requirements
Module: rx_poll_arbiter

Interface
REQ-001 The block SHALL provide parameter NUM_PORTS, default 4: number of receiver ports polled.
REQ-002 The block SHALL provide parameter DATA_W, default 55: packet width per port.
REQ-003 The block SHALL provide parameter TIMEOUT, default 16 (legal range 1..255): maximum POLL cycles per port.
REQ-004 Clk_S  input  1  single clock; all state updates on the rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 Enable  input  1  polling enable.
REQ-007 RX_Data_Valid  input  NUM_PORTS  per-port data-valid from the receivers.
REQ-008 RX_Data_Flat  input  NUM_PORTS*DATA_W  port i packet at bits [i*DATA_W +: DATA_W].
REQ-009 RX_Ready  output  NUM_PORTS  per-port ready, registered, at most one bit high (one-hot or zero).
REQ-010 Out_Valid  output  1  Out_Data and Out_Port hold a captured packet.
REQ-011 Out_Ready  input  1  consumer accepts the packet when high together with Out_Valid.
REQ-012 Out_Data  output  DATA_W  captured packet, registered.
REQ-013 Out_Port  output  clog2(NUM_PORTS)  source port index of Out_Data.
REQ-014 Proto_Err  output  1  sticky flag: a receiver failed to drop valid within TIMEOUT cycles of release.

Function
REQ-015 The block SHALL implement states IDLE, POLL and RELEASE, with a round-robin pointer ptr and an 8-bit cycle counter cnt.
REQ-016 IDLE: when Enable=1 and Out_Valid=0 (after any same-cycle consume), the block SHALL set RX_Ready[ptr]=1, clear cnt and go to POLL; otherwise it SHALL stay in IDLE with RX_Ready=0.
REQ-017 POLL, RX_Data_Valid[ptr]=1: the block SHALL load Out_Data from port ptr, load Out_Port=ptr, set Out_Valid=1, clear RX_Ready, clear cnt and go to RELEASE, all on the same edge.
REQ-018 POLL, no valid and cnt==TIMEOUT-1: the block SHALL clear RX_Ready, advance ptr (NUM_PORTS-1 wraps to 0) and go to IDLE.
REQ-019 POLL, no valid and Enable=0: the block SHALL clear RX_Ready and go to IDLE with ptr unchanged; valid takes priority over Enable=0 and over timeout.
REQ-020 POLL otherwise: the block SHALL increment cnt.
REQ-021 RELEASE: when RX_Data_Valid[ptr]=0, the block SHALL advance ptr (with wrap) and go to IDLE; Enable SHALL NOT affect RELEASE.
REQ-022 RELEASE: while valid stays high, cnt SHALL increment and saturate; on cnt reaching TIMEOUT, Proto_Err SHALL set, and the block SHALL keep waiting.
REQ-023 The block SHALL ignore RX_Data_Valid of non-selected ports in all states.
REQ-024 Out_Valid SHALL stay high with Out_Data/Out_Port stable until a cycle with Out_Ready=1, then clear on that edge.
REQ-025 A grant SHALL NOT be issued while Out_Valid=1, unless the packet is consumed in the same cycle.
REQ-026 Minimum latency SHALL be: RX_Ready rises edge N, valid seen edge N+1, Out_Valid high after edge N+1.
REQ-027 Proto_Err SHALL clear only on reset.

Reset
REQ-028 While Rst=1, the block SHALL force state=IDLE, ptr=0, cnt=0, RX_Ready=0, Out_Valid=0, Out_Data=0, Out_Port=0 and Proto_Err=0, immediately and independent of Clk_S.
REQ-029 Reset asserted mid-POLL or mid-RELEASE SHALL drop RX_Ready the same cycle and discard any captured packet.

Verification
REQ-030 The bench SHALL cover: Enable=1, port0 asserts valid 1 cycle after RX_Ready[0] with data 55'h1A5 -> Out_Valid=1, Out_Data=55'h1A5, Out_Port=0, RX_Ready=0 next cycle, ptr=1 after valid drops.
REQ-031 The bench SHALL cover: no port responds, TIMEOUT=16 -> RX_Ready cycles 0001,0010,0100,1000,0001, each high 16 cycles with 1 IDLE cycle between.
REQ-032 The bench SHALL cover: Out_Ready held 0 after capture -> no RX_Ready for 20 cycles, Out_Data stable; Out_Ready=1 -> Out_Valid clears and the next grant goes to ptr+1.
REQ-033 The bench SHALL cover: port2 holds valid high 20 cycles after release -> Proto_Err=1 at cycle 16 and stays set; valid drop -> IDLE with ptr=3.
REQ-034 The bench SHALL cover: Enable=0 mid-POLL on port1 -> RX_Ready=0 next edge, ptr stays 1, and re-enable grants port1.
REQ-035 The bench SHALL cover: Rst pulse mid-RELEASE -> all outputs 0 asynchronously, and the post-reset grant is to port0.

Source files
------------

// File: rtl/rx_poll_arbiter.sv
// rx_poll_arbiter: round-robin poller that captures one packet per grant and flags receivers stuck on valid.
module rx_poll_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 55,
    parameter int TIMEOUT   = 16,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        Clk_S,
    input  logic                        Rst,
    input  logic                        Enable,
    input  logic [NUM_PORTS-1:0]        RX_Data_Valid,
    input  logic [NUM_PORTS*DATA_W-1:0] RX_Data_Flat,
    output logic [NUM_PORTS-1:0]        RX_Ready,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic [DATA_W-1:0]           Out_Data,
    output logic [PW-1:0]               Out_Port,
    output logic                        Proto_Err
);
    typedef enum logic [1:0] {IDLE, POLL, RELEASE} state_t;
    state_t state;
    logic [PW-1:0] ptr;
    logic [7:0] cnt;
    logic sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic [PW-1:0] nxt_ptr;
    logic [NUM_PORTS-1:0] one;
    assign one       = NUM_PORTS'(1);
    assign sel_valid = RX_Data_Valid[ptr];
    assign sel_data  = RX_Data_Flat[32'(ptr)*DATA_W +: DATA_W];
    assign nxt_ptr   = (ptr == PW'(NUM_PORTS-1)) ? '0 : ptr + PW'(1);
    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            RX_Ready  <= '0;
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Port  <= '0;
            Proto_Err <= 1'b0;
        end else begin
            if (Out_Valid && Out_Ready)
                Out_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    // a packet consumed this cycle frees the output for a new grant
                    if (Enable && (!Out_Valid || Out_Ready)) begin
                        RX_Ready <= one << ptr;
                        cnt      <= '0;
                        state    <= POLL;
                    end else begin
                        RX_Ready <= '0;
                    end
                end
                POLL: begin
                    if (sel_valid) begin
                        Out_Data  <= sel_data;
                        Out_Port  <= ptr;
                        Out_Valid <= 1'b1;
                        RX_Ready  <= '0;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else if (cnt == 8'(TIMEOUT-1)) begin
                        RX_Ready <= '0;
                        ptr      <= nxt_ptr;
                        state    <= IDLE;
                    end else if (!Enable) begin
                        RX_Ready <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!sel_valid) begin
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end else begin
                        if (cnt != 8'hFF)
                            cnt <= cnt + 8'd1;
                        if (cnt == 8'(TIMEOUT-1))
                            Proto_Err <= 1'b1;
                    end
                end
                default: begin
                    RX_Ready <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_poll_arbiter.sv
// tb_rx_poll_arbiter: directed scenarios with a packet scoreboard for rx_poll_arbiter.
module tb_rx_poll_arbiter;
    localparam int NP = 4;
    localparam int DW = 55;
    localparam int TO = 16;
    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } pkt_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic ordy = 1'b0;
    logic [NP-1:0] vld = '0;
    logic [NP*DW-1:0] flat = '0;
    logic [NP-1:0] rdy;
    logic ov;
    logic [DW-1:0] od;
    logic [1:0] op;
    logic perr;
    int n_tests = 0;
    int n_fail = 0;
    pkt_t sb[$];
    rx_poll_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clk_S(clk), .Rst(rst), .Enable(en), .RX_Data_Valid(vld), .RX_Data_Flat(flat),
        .RX_Ready(rdy), .Out_Valid(ov), .Out_Ready(ordy), .Out_Data(od), .Out_Port(op),
        .Proto_Err(perr)
    );
    always #5 clk = ~clk;
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_port(input int p, input logic [DW-1:0] d, input logic push);
        pkt_t pk;
        flat[p*DW +: DW] = d;
        vld[p] = 1'b1;
        pk.port = 2'(p);
        pk.data = d;
        if (push)
            sb.push_back(pk);
    endtask
    // every accepted packet must match the oldest one offered
    always @(negedge clk) begin
        if (!rst && ov && ordy) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_pop", 64'(ov), 64'd0);
            end else begin
                pkt_t pk;
                pk = sb.pop_front();
                check_eq("sb_data", 64'(od), 64'(pk.data));
                check_eq("sb_port", 64'(op), 64'(pk.port));
            end
        end
    end
    initial begin
        int seq[6] = '{3, 0, 1, 2, 3, 0};
        #1 rst = 1'b1;
        #1;
        check_eq("rst_rdy", 64'(rdy), 64'd0);
        check_eq("rst_ov", 64'(ov), 64'd0);
        check_eq("rst_perr", 64'(perr), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        // single capture from port 0
        en = 1'b1;
        tick();
        check_eq("grant0", 64'(rdy), 64'b0001);
        drive_port(0, 55'h1A5, 1'b1);
        tick();
        check_eq("cap_ov", 64'(ov), 64'd1);
        check_eq("cap_data", 64'(od), 64'h1A5);
        check_eq("cap_port", 64'(op), 64'd0);
        check_eq("cap_rdy", 64'(rdy), 64'd0);
        vld = '0;
        tick();
        check_eq("blocked_rdy", 64'(rdy), 64'd0);
        check_eq("held_ov", 64'(ov), 64'd1);
        ordy = 1'b1;
        tick();
        check_eq("grant1", 64'(rdy), 64'b0010);
        check_eq("consumed_ov", 64'(ov), 64'd0);
        // other ports' valid is ignored while polling port 1
        vld = 4'b1101;
        tick();
        check_eq("ignore_rdy", 64'(rdy), 64'b0010);
        check_eq("ignore_ov", 64'(ov), 64'd0);
        vld = '0;
        // disable mid-poll keeps ptr
        en = 1'b0;
        tick();
        check_eq("dis_rdy", 64'(rdy), 64'd0);
        tick();
        tick();
        check_eq("dis_idle_rdy", 64'(rdy), 64'd0);
        en = 1'b1;
        tick();
        check_eq("reen_grant1", 64'(rdy), 64'b0010);
        // capture held by backpressure
        ordy = 1'b0;
        drive_port(1, 55'h7_0000_1234_5678, 1'b1);
        tick();
        check_eq("bp_ov", 64'(ov), 64'd1);
        check_eq("bp_port", 64'(op), 64'd1);
        vld = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("bp_rdy", 64'(rdy), 64'd0);
            check_eq("bp_data", 64'(od), 64'h7_0000_1234_5678);
        end
        ordy = 1'b1;
        tick();
        check_eq("bp_release_ov", 64'(ov), 64'd0);
        check_eq("grant2", 64'(rdy), 64'b0100);
        // port 2 keeps valid high after capture
        drive_port(2, 55'h2BAD, 1'b1);
        tick();
        check_eq("p2_cap_port", 64'(op), 64'd2);
        for (int i = 1; i < TO; i++) begin
            tick();
            check_eq("perr_early", 64'(perr), 64'd0);
        end
        tick();
        check_eq("perr_set", 64'(perr), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("perr_hold", 64'(perr), 64'd1);
            check_eq("stuck_rdy", 64'(rdy), 64'd0);
        end
        vld = '0;
        tick();
        check_eq("stuck_idle_rdy", 64'(rdy), 64'd0);
        tick();
        check_eq("grant3", 64'(rdy), 64'b1000);
        // no responders: each port polled TIMEOUT cycles with one idle gap
        foreach (seq[j]) begin
            for (int k = 0; k < TO; k++) begin
                check_eq("to_rdy", 64'(rdy), 64'(1) << seq[j]);
                tick();
            end
            check_eq("to_gap", 64'(rdy), 64'd0);
            tick();
        end
        check_eq("to_next", 64'(rdy), 64'b0010);
        check_eq("perr_sticky", 64'(perr), 64'd1);
        // reset during release discards the captured packet
        ordy = 1'b0;
        drive_port(1, 55'h5555, 1'b0);
        tick();
        check_eq("pre_rst_ov", 64'(ov), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_rdy", 64'(rdy), 64'd0);
        check_eq("arst_ov", 64'(ov), 64'd0);
        check_eq("arst_data", 64'(od), 64'd0);
        check_eq("arst_port", 64'(op), 64'd0);
        check_eq("arst_perr", 64'(perr), 64'd0);
        vld = '0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_grant0", 64'(rdy), 64'b0001);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
